// File: rtl/vend_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------------------------
// vend_ctrl_fsm_if
// Purpose : groups the event/status bundle exchanged between the vending sequencer and the
//           touch/coin/price driver.
// Modports:
//   master - sequencer side (vend_ctrl_fsm): takes touch events and driver status, drives
//            phase levels, commit pulses, motor request and diagnostics.
//   slave  - driver side: the mirror image of master.
// Signals :
//   select_flag, sure_flag, cancel_flag, charge_flag, coin_sig   touch-decoded events
//   coin_ov_flag, nonenough_flag, coin_val_sum[10:0], product_number[3:0], dispense_ack
//   selected_sta_flag, coin_sta_flag, pay_sta_flag               phase levels
//   coin_fn_flag, pay_st_flag, charge_st_flag                    commit pulses
//   dispense_req, vend_product[3:0]                              motor handshake
//   change_val[10:0], coin_reject, short_pulse, disp_fault, state[2:0]
// ---------------------------------------------------------------------------------------------
interface vend_ctrl_fsm_if;
  logic        select_flag;
  logic        sure_flag;
  logic        cancel_flag;
  logic        charge_flag;
  logic        coin_sig;
  logic        coin_ov_flag;
  logic        nonenough_flag;
  logic [10:0] coin_val_sum;
  logic [3:0]  product_number;
  logic        dispense_ack;

  logic        selected_sta_flag;
  logic        coin_sta_flag;
  logic        coin_fn_flag;
  logic        pay_sta_flag;
  logic        pay_st_flag;
  logic        charge_st_flag;
  logic        dispense_req;
  logic [3:0]  vend_product;
  logic [10:0] change_val;
  logic        coin_reject;
  logic        short_pulse;
  logic        disp_fault;
  logic [2:0]  state;

  modport master (
    input  select_flag, sure_flag, cancel_flag, charge_flag, coin_sig, coin_ov_flag,
           nonenough_flag, coin_val_sum, product_number, dispense_ack,
    output selected_sta_flag, coin_sta_flag, coin_fn_flag, pay_sta_flag, pay_st_flag,
           charge_st_flag, dispense_req, vend_product, change_val, coin_reject, short_pulse,
           disp_fault, state
  );

  modport slave (
    output select_flag, sure_flag, cancel_flag, charge_flag, coin_sig, coin_ov_flag,
           nonenough_flag, coin_val_sum, product_number, dispense_ack,
    input  selected_sta_flag, coin_sta_flag, coin_fn_flag, pay_sta_flag, pay_st_flag,
           charge_st_flag, dispense_req, vend_product, change_val, coin_reject, short_pulse,
           disp_fault, state
  );
endinterface

// File: rtl/vend_ctrl_fsm.sv
// ---------------------------------------------------------------------------------------------
// vend_ctrl_fsm
// Purpose : top-level vending sequencer. Walks IDLE/SELECT/COIN/PAY_CHK/PAY_COMMIT/DISPENSE/
//           CHARGE, issues commit pulses to the driver, runs the dispense-motor handshake and
//           the inactivity / dispense watchdogs.
// Ports   :
//   i_clk    system clock
//   i_rst    synchronous active-high reset
//   io_vend  vend_ctrl_fsm_if.master bundle (events in; levels, pulses, status out)
// ---------------------------------------------------------------------------------------------
module vend_ctrl_fsm #(
  parameter int unsigned IDLE_TO = 500000000,
  parameter int unsigned DISP_TO = 100000000,
  parameter int unsigned CNT_W   = 29
) (
  input  logic            i_clk,
  input  logic            i_rst,
  vend_ctrl_fsm_if.master io_vend
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StSelect    = 3'd1,
    StCoin      = 3'd2,
    StPayChk    = 3'd3,
    StPayCommit = 3'd4,
    StDispense  = 3'd5,
    StCharge    = 3'd6
  } state_e;

  state_e           r_state, w_state_nxt;
  logic             r_coin_pend, r_coin_fn, r_coin_reject, r_short;
  logic             r_pay_st, r_charge_st, r_disp_req, r_disp_fault;
  logic [3:0]       r_vend_product;
  logic [10:0]      r_change_val;
  logic [CNT_W-1:0] r_wdog, w_wdog_nxt;

  logic w_bal_nz, w_prod_nz, w_any_evt, w_coin_ok, w_idle_to, w_disp_to;
  logic w_coin_take, w_short_set;

  assign w_bal_nz  = (io_vend.coin_val_sum != 11'd0);
  assign w_prod_nz = (io_vend.product_number != 4'd0);
  assign w_any_evt = io_vend.select_flag | io_vend.sure_flag | io_vend.cancel_flag |
                     io_vend.charge_flag | io_vend.coin_sig;
  // A coin is refused while the previous one is still being committed.
  assign w_coin_ok = io_vend.coin_sig & ~r_coin_pend & ~r_coin_fn;
  // Watchdog has the lowest priority: any touch event this cycle pre-empts it.
  assign w_idle_to = (r_wdog == CNT_W'(IDLE_TO - 1)) & ~w_any_evt;
  assign w_disp_to = (r_wdog == CNT_W'(DISP_TO - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_coin_take = 1'b0;
    w_short_set = 1'b0;
    case (r_state)
      StIdle: begin
        if (io_vend.charge_flag && w_bal_nz) begin
          w_state_nxt = StCharge;
        end else if (w_coin_ok) begin
          w_state_nxt = StCoin;
          w_coin_take = 1'b1;
        end else if (io_vend.select_flag) begin
          w_state_nxt = StSelect;
        end
      end
      StSelect: begin
        if (io_vend.cancel_flag) begin
          w_state_nxt = StIdle;
        end else if (io_vend.charge_flag && w_bal_nz) begin
          w_state_nxt = StCharge;
        end else if (io_vend.sure_flag && w_prod_nz) begin
          w_state_nxt = StPayChk;
        end else if (w_coin_ok) begin
          w_state_nxt = StCoin;
          w_coin_take = 1'b1;
        end else if (w_idle_to) begin
          w_state_nxt = StIdle;
        end
      end
      StCoin: begin
        // Hold in COIN until the pending coin has been committed or rejected.
        if (r_coin_pend) begin
          w_state_nxt = StCoin;
        end else if (io_vend.cancel_flag || io_vend.charge_flag) begin
          w_state_nxt = w_bal_nz ? StCharge : StIdle;
        end else if (io_vend.sure_flag && w_prod_nz) begin
          w_state_nxt = StPayChk;
        end else if (w_coin_ok) begin
          w_coin_take = 1'b1;
        end else if (io_vend.select_flag) begin
          w_state_nxt = StSelect;
        end else if (w_idle_to) begin
          w_state_nxt = w_bal_nz ? StCharge : StIdle;
        end
      end
      StPayChk: begin
        if (io_vend.nonenough_flag) begin
          w_state_nxt = StCoin;
          w_short_set = 1'b1;
        end else begin
          w_state_nxt = StPayCommit;
        end
      end
      StPayCommit: w_state_nxt = StDispense;
      StDispense: begin
        if (io_vend.dispense_ack) begin
          w_state_nxt = w_bal_nz ? StCoin : StIdle;
        end else if (w_disp_to) begin
          w_state_nxt = StIdle;
        end
      end
      StCharge: w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Touch events do not restart the dispense watchdog, so a stuck motor always times out.
  always_comb begin
    w_wdog_nxt = r_wdog;
    if (w_state_nxt != r_state) begin
      w_wdog_nxt = '0;
    end else if (w_any_evt && (r_state != StDispense)) begin
      w_wdog_nxt = '0;
    end else if (((r_state == StSelect) || (r_state == StCoin) || (r_state == StDispense)) &&
                 (r_wdog != '1)) begin
      w_wdog_nxt = r_wdog + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_coin_pend    <= 1'b0;
      r_coin_fn      <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_short        <= 1'b0;
      r_pay_st       <= 1'b0;
      r_charge_st    <= 1'b0;
      r_disp_req     <= 1'b0;
      r_disp_fault   <= 1'b0;
      r_vend_product <= 4'd0;
      r_change_val   <= 11'd0;
      r_wdog         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_coin_pend   <= w_coin_take;
      r_coin_fn     <= r_coin_pend & ~io_vend.coin_ov_flag;
      r_coin_reject <= r_coin_pend & io_vend.coin_ov_flag;
      r_short       <= w_short_set;
      // These track the state being entered so they are high for exactly that state's cycles.
      r_pay_st      <= (w_state_nxt == StPayCommit);
      r_charge_st   <= (w_state_nxt == StCharge);
      r_disp_req    <= (w_state_nxt == StDispense);
      r_wdog        <= w_wdog_nxt;
      if (r_state == StPayChk) begin
        r_vend_product <= io_vend.product_number;
      end
      if (r_state == StCharge) begin
        r_change_val <= io_vend.coin_val_sum;
      end
      if ((r_state == StDispense) && !io_vend.dispense_ack && w_disp_to) begin
        r_disp_fault <= 1'b1;
      end
    end
  end

  assign io_vend.selected_sta_flag = (r_state == StSelect);
  assign io_vend.coin_sta_flag     = (r_state == StCoin);
  assign io_vend.pay_sta_flag      = (r_state == StPayChk);
  assign io_vend.coin_fn_flag      = r_coin_fn;
  assign io_vend.pay_st_flag       = r_pay_st;
  assign io_vend.charge_st_flag    = r_charge_st;
  assign io_vend.dispense_req      = r_disp_req;
  assign io_vend.vend_product      = r_vend_product;
  assign io_vend.change_val        = r_change_val;
  assign io_vend.coin_reject       = r_coin_reject;
  assign io_vend.short_pulse       = r_short;
  assign io_vend.disp_fault        = r_disp_fault;
  assign io_vend.state             = r_state;

endmodule
